// File: rtl/burst_memory_responder.sv
// Memory-side responder for the 4x64-bit line burst protocol.
// A request is accepted in IDLE, a programmable latency elapses, then four
// consecutive 64-bit beats are streamed (read) or absorbed (write). The line
// store is a plain array organised as {line index, beat} and is never cleared.
module burst_memory_responder #(
    parameter int LINE_IDX_BITS = 8,
    parameter int READ_LAT      = 4,
    parameter int WRITE_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        proto_err_o
);

    localparam int MEM_AW = LINE_IDX_BITS + 2;
    localparam int MEM_WORDS = 2 ** MEM_AW;
    // The latency counter is loaded with LAT-1 so that LAT=1 gives a beat on
    // the cycle straight after accept.
    localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAT   = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                     state_r, state_s;
    logic                       op_read_r, op_read_s;
    logic [LINE_IDX_BITS-1:0]   idx_r, idx_s;
    logic [3:0]                 cnt_r, cnt_s;
    logic [1:0]                 beat_r, beat_s;
    logic                       resp_r, resp_s;
    logic [63:0]                burst_r, burst_s;
    logic                       err_r, err_s;
    logic                       req_ok_s;
    logic                       mem_we_s;
    logic [63:0]                mem_r [0:MEM_WORDS-1];

    // Offset bits and aliased upper address bits are intentionally ignored.
    logic                       addr_unused_s;
    assign addr_unused_s = ^{address_i[31:5+LINE_IDX_BITS], address_i[4:0]};

    assign burst_o     = burst_r;
    assign resp_o      = resp_r;
    assign proto_err_o = err_r;

    // Next-state, next-output and write-enable logic for the transaction FSM.
    always_comb begin
        state_s   = state_r;
        op_read_s = op_read_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        beat_s    = beat_r;
        resp_s    = 1'b0;
        burst_s   = 64'd0;
        err_s     = err_r;
        mem_we_s  = 1'b0;
        // The latched op must stay requested; for a write, a rising read_i is
        // an op switch (reads win when both are high at accept).
        req_ok_s  = op_read_r ? read_i : (write_i & ~read_i);

        case (state_r)
            IDLE: begin
                if (read_i || write_i) begin
                    state_s   = LAT;
                    op_read_s = read_i;
                    idx_s     = address_i[5 +: LINE_IDX_BITS];
                    cnt_s     = read_i ? RD_CNT : WR_CNT;
                end else begin
                    state_s = IDLE;
                end
            end
            LAT: begin
                if (!req_ok_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (cnt_r == 4'd0) begin
                    state_s = BURST;
                    beat_s  = 2'd0;
                    resp_s  = 1'b1;
                    if (op_read_r) begin
                        burst_s = mem_r[{idx_r, 2'd0}];
                    end else begin
                        burst_s = 64'd0;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            BURST: begin
                if (!req_ok_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                mem_we_s = ~op_read_r;
                if (beat_r == 2'd3) begin
                    state_s = DRAIN;
                end else begin
                    beat_s = beat_r + 2'd1;
                    resp_s = 1'b1;
                    if (op_read_r) begin
                        burst_s = mem_r[{idx_r, beat_r + 2'd1}];
                    end else begin
                        burst_s = 64'd0;
                    end
                end
            end
            DRAIN: begin
                if (!read_i && !write_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            op_read_r <= 1'b0;
            idx_r     <= '0;
            cnt_r     <= 4'd0;
            beat_r    <= 2'd0;
            resp_r    <= 1'b0;
            burst_r   <= 64'd0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            op_read_r <= op_read_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            beat_r    <= beat_s;
            resp_r    <= resp_s;
            burst_r   <= burst_s;
            err_r     <= err_s;
        end
    end

    // Line store write port; a reset edge suppresses the in-flight beat.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_r[{idx_r, beat_r}] <= burst_i;
        end
    end

endmodule

// File: tb/tb_burst_memory_responder.sv
// Directed bench for burst_memory_responder: a table of whole transactions
// plus hand sequences for request drop and reset in the middle of a write.
module tb_burst_memory_responder;

    localparam int READ_LAT  = 4;
    localparam int WRITE_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_i = 32'd0;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [63:0] burst_i = 64'd0;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        proto_err_o;

    int checks = 0;
    int errors = 0;

    burst_memory_responder #(
        .LINE_IDX_BITS(8),
        .READ_LAT(READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address_i(address_i),
        .read_i(read_i),
        .write_i(write_i),
        .burst_i(burst_i),
        .burst_o(burst_o),
        .resp_o(resp_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               rd;
        bit               wr;
        logic [31:0]      addr;
        logic [3:0][63:0] data;
        bit               exp_err;
    } txn_t;

    txn_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction. data = write beats or expected read beats.
    // drop_n: LAT cycle at which the request is dropped (0 = never).
    // rst_beat: beat during which reset is raised (-1 = never).
    task automatic txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [3:0][63:0] data, input int drop_n, input int rst_beat,
                       input bit exp_err);
        int  lat;
        int  n;
        bit  seen;
        bit  aborted;
        lat = rd ? READ_LAT : WRITE_LAT;
        address_i = addr;
        read_i    = rd;
        write_i   = wr;
        burst_i   = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        #1 address_i = addr ^ 32'h0000_1FE0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (resp_o) begin
                seen = 1'b1;
            end else begin
                chk({tag, " burst_o idle"}, burst_o, 64'd0);
                if (n == drop_n) begin
                    read_i  = 1'b0;
                    write_i = 1'b0;
                end
            end
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        aborted = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("%s resp beat%0d", tag, b), {63'd0, resp_o}, 64'd1);
            end
            if (b == rst_beat) begin
                reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (rd) begin
                chk($sformatf("%s rdata beat%0d", tag, b), burst_o, data[b]);
            end else begin
                chk($sformatf("%s burst_o write beat%0d", tag, b), burst_o, 64'd0);
                burst_i = data[b];
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, aborted ? " resp after reset" : " resp after burst"}, {63'd0, resp_o}, 64'd0);
        chk({tag, " burst_o after burst"}, burst_o, 64'd0);
        reset   = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        burst_i = 64'd0;
        @(posedge clk);
        #1;
        chk({tag, " proto_err"}, {63'd0, proto_err_o}, {63'd0, exp_err});
    endtask

    localparam logic [3:0][63:0] P = {64'h2222_0000_0000_0003, 64'h2222_0000_0000_0002,
                                      64'h2222_0000_0000_0001, 64'h2222_0000_0000_0000};
    localparam logic [3:0][63:0] A = {64'hA3A3_A3A3_0000_FFFF, 64'hA2A2_A2A2_1234_5678,
                                      64'hA1A1_A1A1_DEAD_BEEF, 64'hA0A0_A0A0_0F0F_0F0F};
    localparam logic [3:0][63:0] B = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                                      64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};

    initial begin
        tbl[0] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0040, data: P, exp_err: 1'b0};
        tbl[1] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0040, data: P, exp_err: 1'b0};
        tbl[2] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0100, data: A, exp_err: 1'b0};
        tbl[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0100, data: A, exp_err: 1'b0};
        tbl[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'h2000_0100, data: A, exp_err: 1'b0};
        tbl[5] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_005F, data: P, exp_err: 1'b0};
        tbl[6] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0040, data: P, exp_err: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset resp_o", {63'd0, resp_o}, 64'd0);
        chk("reset burst_o", burst_o, 64'd0);
        chk("reset proto_err", {63'd0, proto_err_o}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            txn($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                0, -1, tbl[i].exp_err);
        end

        // Request dropped during latency: error sticks, four beats still arrive.
        txn("drop", 1'b1, 1'b0, 32'h0000_0100, A, 2, -1, 1'b1);

        // Reset raised in beat 2 of a write: only beats 0-1 land, error clears.
        txn("rstwr", 1'b0, 1'b1, 32'h0000_0100, B, 0, 2, 1'b0);
        txn("rstrd", 1'b1, 1'b0, 32'h0000_0100, {A[3], A[2], B[1], B[0]}, 0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
